ikbd_serial_bridge: RTL and testbench

Host-side endpoint of the IKBD serial link. It consumes the 8N1 stream the keyboard MCU SCI drives on its TX pin, deserialises it into a receive FIFO for the host, and serialises host bytes onto the MCU SCI RX pin. It sits directly downstream of the MCU SCI transmitter and upstream of its receiver, clocked on the same CLKx2/clken timebase so bit timing matches the SCI's 256-tick bit cell.

---
 rtl/ikbd_link_pkg.sv | 30 +++
 rtl/ikbd_sync_fifo.sv | 69 ++++++
 rtl/ikbd_serial_bridge.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ikbd_serial_bridge.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ikbd_link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ikbd_link_pkg                                          |
// | Description : Shared constants and FSM state types for the IKBD      |
// |               serial link endpoint (8N1 framing, SCI bit timing).    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ikbd_link_pkg;

    // clken ticks per serial bit; matches the MCU SCI 256-tick bit cell
    localparam int C_BIT_TICKS_DEF = 256;
    // start + 8 data + stop
    localparam int C_FRAME_BITS    = 10;
    localparam int C_DATA_BITS     = 8;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

    typedef enum logic [0:0] {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/ikbd_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ikbd_sync_fifo                                         |
// | Description : Show-ahead synchronous FIFO with occupancy output.     |
// |               A push into a full FIFO is accepted when a pop happens |
// |               on the same edge. Pops while empty are ignored.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ikbd_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q,  level_d;
    logic             w_push,   w_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign w_pop   = pop_i & ~empty_o;
    assign w_push  = push_i & (~full_o | w_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Occupancy follows the net effect of push and pop on this edge
    always_comb begin
        level_d = level_q;
        if (w_push && !w_pop) begin
            level_d = level_q + LW'(1);
        end else if (w_pop && !w_push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ikbd_serial_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ikbd_serial_bridge                                     |
// | Description : Host-side IKBD link endpoint. Deserialises the MCU SCI |
// |               TX stream into a receive FIFO and serialises host      |
// |               bytes onto the MCU SCI RX pin, both on clken timing.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ikbd_serial_bridge
    import ikbd_link_pkg::*;
#(
    parameter int BIT_TICKS  = C_BIT_TICKS_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLKx2,
    input  logic                          mcu_rst,
    input  logic                          clken,
    input  logic                          ikbd_txd,
    output logic                          ikbd_rxd,
    output logic                          host_rvalid,
    output logic [7:0]                    host_rdata,
    input  logic                          host_rd,
    output logic                          host_wready,
    input  logic                          host_wr,
    input  logic [7:0]                    host_wdata,
    output logic                          rx_ovr,
    output logic                          rx_ferr,
    input  logic                          err_clr,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level
);
    localparam int            TW          = $clog2(BIT_TICKS);
    localparam logic [TW-1:0] C_TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0] C_TICK_HALF = TW'(BIT_TICKS / 2 - 1);

    // ---------------- input synchroniser ----------------
    logic [1:0] sync_q;
    logic       line_prev_q;
    logic       w_line, w_fall;

    assign w_line = sync_q[1];
    assign w_fall = line_prev_q & ~w_line;

    // Two-flop synchroniser plus one delayed copy for falling-edge detect
    always_ff @(posedge CLKx2 or posedge mcu_rst) begin
        if (mcu_rst) begin
            sync_q      <= 2'b11;
            line_prev_q <= 1'b1;
        end else begin
            sync_q      <= {sync_q[0], ikbd_txd};
            line_prev_q <= sync_q[1];
        end
    end

    // ---------------- receive path ----------------
    rx_state_e     rx_state_q, rx_state_d;
    logic [TW-1:0] rx_tick_q,  rx_tick_d;
    logic [2:0]    rx_bit_q,   rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          w_rx_push, w_ovr_set, w_ferr_set;
    logic          w_fifo_empty, w_fifo_full, w_pop;
    logic          rx_ovr_q, rx_ferr_q;

    assign w_pop = host_rd & ~w_fifo_empty;

    // RX next state: counts clken ticks, samples mid-bit, frames the byte
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        w_rx_push  = 1'b0;
        w_ovr_set  = 1'b0;
        w_ferr_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (w_fall) begin
                    rx_state_d = RX_START;
                    rx_tick_d  = '0;
                end
            end
            RX_START: begin
                if (clken) begin
                    if (rx_tick_q == C_TICK_HALF) begin
                        rx_tick_d = '0;
                        rx_bit_d  = '0;
                        // a high line at mid start bit was only a glitch
                        rx_state_d = w_line ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tick_d = rx_tick_q + TW'(1);
                    end
                end
            end
            RX_DATA: begin
                if (clken) begin
                    if (rx_tick_q == C_TICK_LAST) begin
                        rx_tick_d  = '0;
                        rx_shift_d = {w_line, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'(C_DATA_BITS - 1)) begin
                            rx_state_d = RX_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_tick_d = rx_tick_q + TW'(1);
                    end
                end
            end
            RX_STOP: begin
                if (clken) begin
                    if (rx_tick_q == C_TICK_LAST) begin
                        rx_tick_d = '0;
                        if (w_line) begin
                            rx_state_d = RX_IDLE;
                            // a pop on this same edge frees the slot
                            if (!w_fifo_full || w_pop) begin
                                w_rx_push = 1'b1;
                            end else begin
                                w_ovr_set = 1'b1;
                            end
                        end else begin
                            w_ferr_set = 1'b1;
                            rx_state_d = RX_BREAK;
                        end
                    end else begin
                        rx_tick_d = rx_tick_q + TW'(1);
                    end
                end
            end
            RX_BREAK: begin
                if (w_line) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX state register; reset discards any partial frame
    always_ff @(posedge CLKx2 or posedge mcu_rst) begin
        if (mcu_rst) begin
            rx_state_q <= RX_IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Sticky error flags; a new error on the clear edge keeps the flag set
    always_ff @(posedge CLKx2 or posedge mcu_rst) begin
        if (mcu_rst) begin
            rx_ovr_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
        end else begin
            rx_ovr_q  <= (rx_ovr_q  & ~err_clr) | w_ovr_set;
            rx_ferr_q <= (rx_ferr_q & ~err_clr) | w_ferr_set;
        end
    end

    assign rx_ovr      = rx_ovr_q;
    assign rx_ferr     = rx_ferr_q;
    assign host_rvalid = ~w_fifo_empty;

    ikbd_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk_i   (CLKx2),
        .rst_i   (mcu_rst),
        .push_i  (w_rx_push),
        .data_i  (rx_shift_q),
        .pop_i   (host_rd),
        .data_o  (host_rdata),
        .empty_o (w_fifo_empty),
        .full_o  (w_fifo_full),
        .level_o (rx_level)
    );

    // ---------------- transmit path ----------------
    // The shifter idles at all-ones so its LSB is directly the line driver.
    tx_state_e     tx_state_q, tx_state_d;
    logic [TW-1:0] tx_tick_q,  tx_tick_d;
    logic [3:0]    tx_bit_q,   tx_bit_d;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic [7:0]    hold_q,     hold_d;
    logic          hold_full_q, hold_full_d;
    logic          w_tx_load;

    assign host_wready = ~hold_full_q;
    assign ikbd_rxd    = tx_shift_q[0];

    // TX next state: holding register handshake, bit timing, frame chaining
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_tick_d   = tx_tick_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        w_tx_load   = 1'b0;
        if (host_wr && !hold_full_q) begin
            hold_d      = host_wdata;
            hold_full_d = 1'b1;
        end
        case (tx_state_q)
            TX_IDLE: begin
                w_tx_load = clken & hold_full_q;
            end
            TX_SHIFT: begin
                if (clken) begin
                    if (tx_tick_q == C_TICK_LAST) begin
                        tx_tick_d = '0;
                        if (tx_bit_q == 4'(C_FRAME_BITS - 1)) begin
                            // stop bit done: chain the next byte with no gap
                            if (hold_full_q) begin
                                w_tx_load = 1'b1;
                            end else begin
                                tx_state_d = TX_IDLE;
                            end
                        end else begin
                            tx_shift_d = {1'b1, tx_shift_q[9:1]};
                            tx_bit_d   = tx_bit_q + 4'd1;
                        end
                    end else begin
                        tx_tick_d = tx_tick_q + TW'(1);
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (w_tx_load) begin
            tx_shift_d  = {1'b1, hold_q, 1'b0};
            tx_tick_d   = '0;
            tx_bit_d    = '0;
            tx_state_d  = TX_SHIFT;
            hold_full_d = 1'b0;
        end
    end

    // TX state register; reset returns the line to idle-high at once
    always_ff @(posedge CLKx2 or posedge mcu_rst) begin
        if (mcu_rst) begin
            tx_state_q  <= TX_IDLE;
            tx_tick_q   <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '1;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_tick_q   <= tx_tick_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ikbd_serial_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ikbd_serial_bridge                                  |
// | Description : Directed self-checking bench for ikbd_serial_bridge    |
// |               with a shortened bit cell and clken every other clock. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ikbd_serial_bridge;
    import ikbd_link_pkg::*;

    localparam int BT = 16;
    localparam int FD = 8;

    logic       CLKx2 = 1'b0;
    logic       mcu_rst = 1'b1;
    logic       clken = 1'b0;
    logic       txd_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       ikbd_rxd;
    logic       host_rvalid;
    logic [7:0] host_rdata;
    logic       host_rd = 1'b0;
    logic       host_wready;
    logic       host_wr = 1'b0;
    logic [7:0] host_wdata = 8'h00;
    logic       rx_ovr, rx_ferr;
    logic       err_clr = 1'b0;
    logic [3:0] rx_level;

    int n_cmp  = 0;
    int n_fail = 0;

    ikbd_serial_bridge #(
        .BIT_TICKS  (BT),
        .FIFO_DEPTH (FD)
    ) dut (
        .CLKx2       (CLKx2),
        .mcu_rst     (mcu_rst),
        .clken       (clken),
        .ikbd_txd    (loop_en ? ikbd_rxd : txd_drv),
        .ikbd_rxd    (ikbd_rxd),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .host_rd     (host_rd),
        .host_wready (host_wready),
        .host_wr     (host_wr),
        .host_wdata  (host_wdata),
        .rx_ovr      (rx_ovr),
        .rx_ferr     (rx_ferr),
        .err_clr     (err_clr),
        .rx_level    (rx_level)
    );

    always #5 CLKx2 = ~CLKx2;

    // clken high on every other clock, changed just after the edge
    always @(posedge CLKx2) begin
        #1 clken = ~clken;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge CLKx2);
            if (clken) c++;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b);
        logic [9:0] f;
        f = {stop_b, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge CLKx2);
            txd_drv = f[i];
            wait_ticks(BT);
        end
    endtask

    task automatic pulse_rd();
        @(negedge CLKx2); host_rd = 1'b1;
        @(negedge CLKx2); host_rd = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge CLKx2); err_clr = 1'b1;
        @(negedge CLKx2); err_clr = 1'b0;
    endtask

    task automatic wait_wready(input string tag);
        int c = 0;
        while (!host_wready && c < 100) begin
            @(negedge CLKx2);
            c++;
        end
        check(tag, 32'(host_wready), 32'd1);
    endtask

    initial begin : main
        logic [19:0] samp;
        logic        hit;

        // ---- reset values ----
        repeat (3) @(negedge CLKx2);
        check("rst_rxd",    32'(ikbd_rxd),    32'd1);
        check("rst_rvalid", 32'(host_rvalid), 32'd0);
        check("rst_level",  32'(rx_level),    32'd0);
        check("rst_wready", 32'(host_wready), 32'd1);
        check("rst_ovr",    32'(rx_ovr),      32'd0);
        check("rst_ferr",   32'(rx_ferr),     32'd0);
        mcu_rst = 1'b0;
        repeat (4) @(negedge CLKx2);

        // ---- loopback 0xA5 ----
        loop_en = 1'b1;
        host_wdata = 8'hA5; host_wr = 1'b1;
        @(negedge CLKx2); host_wr = 1'b0;
        check("lb_wready_drop", 32'(host_wready), 32'd0);
        wait_ticks(11 * BT);
        @(negedge CLKx2);
        check("lb_rvalid", 32'(host_rvalid), 32'd1);
        check("lb_rdata",  32'(host_rdata),  32'hA5);
        check("lb_level",  32'(rx_level),    32'd1);
        check("lb_ovr",    32'(rx_ovr),      32'd0);
        check("lb_ferr",   32'(rx_ferr),     32'd0);
        pulse_rd();
        check("lb_pop_level", 32'(rx_level), 32'd0);
        loop_en = 1'b0;
        pulse_rd();
        check("rd_empty_level", 32'(rx_level), 32'd0);

        // ---- glitch shorter than half a bit ----
        @(negedge CLKx2); txd_drv = 1'b0;
        wait_ticks(3);
        @(negedge CLKx2); txd_drv = 1'b1;
        wait_ticks(2 * BT);
        @(negedge CLKx2);
        check("gl_state", 32'(dut.rx_state_q), 32'(RX_IDLE));
        check("gl_level", 32'(rx_level),       32'd0);
        check("gl_ferr",  32'(rx_ferr),        32'd0);

        // ---- framing error then recovery ----
        send_frame(8'h3C, 1'b0);
        wait_ticks(3 * BT);
        @(negedge CLKx2); txd_drv = 1'b1;
        wait_ticks(BT);
        @(negedge CLKx2);
        check("fe_ferr",   32'(rx_ferr),     32'd1);
        check("fe_rvalid", 32'(host_rvalid), 32'd0);
        send_frame(8'h12, 1'b1);
        @(negedge CLKx2);
        check("fe_next_data",  32'(host_rdata), 32'h12);
        check("fe_next_level", 32'(rx_level),   32'd1);
        check("fe_sticky",     32'(rx_ferr),    32'd1);
        pulse_clr();
        check("fe_clr", 32'(rx_ferr), 32'd0);
        pulse_rd();

        // ---- overrun ----
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
        @(negedge CLKx2);
        check("ov_level", 32'(rx_level), 32'd8);
        check("ov_flag",  32'(rx_ovr),   32'd1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ov_pop%0d", i), 32'(host_rdata), 32'(i));
            pulse_rd();
        end
        check("ov_empty", 32'(host_rvalid), 32'd0);
        pulse_clr();
        check("ov_clr", 32'(rx_ovr), 32'd0);

        // ---- push/pop collision on a full FIFO ----
        for (int i = 0; i < 8; i++) send_frame(8'h60 + 8'(i), 1'b1);
        @(negedge CLKx2);
        check("co_full", 32'(rx_level), 32'd8);
        hit = 1'b0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                for (int c = 0; c < 400 && !hit; c++) begin
                    @(negedge CLKx2);
                    if (dut.rx_state_q == RX_STOP && dut.rx_tick_q == 4'(BT - 1) && clken) begin
                        host_rd = 1'b1;
                        @(negedge CLKx2);
                        host_rd = 1'b0;
                        hit = 1'b1;
                    end
                end
            end
        join
        check("co_hit",   32'(hit),        32'd1);
        @(negedge CLKx2);
        check("co_ovr",   32'(rx_ovr),     32'd0);
        check("co_level", 32'(rx_level),   32'd8);
        check("co_head",  32'(host_rdata), 32'h61);
        for (int i = 0; i < 7; i++) pulse_rd();
        check("co_tail",  32'(host_rdata), 32'h55);
        check("co_last",  32'(rx_level),   32'd1);
        pulse_rd();

        // ---- TX back-to-back frames ----
        @(negedge CLKx2);
        host_wdata = 8'h80; host_wr = 1'b1;
        @(negedge CLKx2);
        check("tx_busy", 32'(host_wready), 32'd0);
        host_wdata = 8'hFF;
        @(negedge CLKx2); host_wr = 1'b0;
        wait_wready("tx_load1");
        check("tx_start", 32'(ikbd_rxd), 32'd0);
        host_wdata = 8'h01; host_wr = 1'b1;
        @(negedge CLKx2); host_wr = 1'b0;
        wait_ticks(BT / 2 - 1);
        @(negedge CLKx2);
        samp[0] = ikbd_rxd;
        for (int i = 1; i < 20; i++) begin
            wait_ticks(BT);
            @(negedge CLKx2);
            samp[i] = ikbd_rxd;
        end
        check("tx_frames", 32'(samp), 32'h80B00);

        // ---- reset in the middle of a second frame ----
        wait_ticks(BT);
        @(negedge CLKx2);
        host_wdata = 8'h00; host_wr = 1'b1;
        @(negedge CLKx2); host_wr = 1'b0;
        wait_wready("tx_load2");
        host_wr = 1'b1;
        @(negedge CLKx2); host_wr = 1'b0;
        wait_ticks(12 * BT + 8);
        @(negedge CLKx2);
        check("tx_mid_low", 32'(ikbd_rxd), 32'd0);
        mcu_rst = 1'b1;
        #1;
        check("rst_mid_rxd",    32'(ikbd_rxd),    32'd1);
        check("rst_mid_wready", 32'(host_wready), 32'd1);
        check("rst_mid_rvalid", 32'(host_rvalid), 32'd0);
        repeat (2) @(negedge CLKx2);
        mcu_rst = 1'b0;
        wait_ticks(2 * BT);
        @(negedge CLKx2);
        check("post_rst_rxd", 32'(ikbd_rxd), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
